// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: PC ownership, load-use hazard
// detection, branch flush, memory-stall freeze and saturating event counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [31:0]      instr_addr_o,
  input  logic [31:0]      instr_i,
  input  logic             MemStall_i,
  input  logic             Branch_i,
  input  logic [31:0]      branch_target_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RDaddr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instruction_o,
  output logic             valid_o,
  output logic             NoOp_o,
  output logic [CNT_W-1:0] load_use_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [31:0] pc_q;
  logic        hazard;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        take_branch;

  assign instr_addr_o = pc_q;

  // rs2 is compared for every opcode, so some stalls are conservative.
  assign rs1_hit = (IDEX_RDaddr_i == instruction_o[19:15]);
  assign rs2_hit = (IDEX_RDaddr_i == instruction_o[24:20]);
  assign hazard  = valid_o & IDEX_MemRead_i & (IDEX_RDaddr_i != 5'd0) & (rs1_hit | rs2_hit);
  assign NoOp_o  = hazard;

  assign take_branch = Branch_i & valid_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q           <= RESET_PC;
      pc_o           <= '0;
      instruction_o  <= NOP_INSTR;
      valid_o        <= 1'b0;
      load_use_cnt_o <= '0;
      flush_cnt_o    <= '0;
    end else if (MemStall_i) begin
      // Full freeze; hazard and branch re-evaluate once the stall lifts.
    end else if (hazard) begin
      if (load_use_cnt_o != '1) load_use_cnt_o <= load_use_cnt_o + 1'b1;
    end else if (take_branch) begin
      pc_q          <= branch_target_i;
      pc_o          <= pc_q;
      instruction_o <= NOP_INSTR;
      valid_o       <= 1'b0;
      if (flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 1'b1;
    end else begin
      pc_q          <= pc_q + 32'd4;
      pc_o          <= pc_q;
      instruction_o <= instr_i;
      valid_o       <= 1'b1;
    end
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage pipelined RISC-V CPU, sitting directly upstream of the ID/EX register.
- Owns the PC, addresses instruction memory, and latches PC/instruction into IF/ID.
- Contains load-use hazard detection, which drives the control-zeroing NoOp into ID/EX.
- Handles branch flush (branch resolved in ID) and the global cache memory stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC value on reset.
- NOP_INSTR, 32'h0000_0013, instruction inserted on reset/flush (addi x0,x0,0).
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk_i  in  1  clock, posedge.
- rst_i  in  1  asynchronous active-low reset.
- instr_addr_o  out  32  instruction memory address = current PC.
- instr_i  in  32  instruction memory read data (combinational from instr_addr_o).
- MemStall_i  in  1  data-cache stall; freezes all state.
- Branch_i  in  1  taken branch resolved in ID for the instruction currently in IF/ID.
- branch_target_i  in  32  branch target from ID.
- IDEX_MemRead_i  in  1  instruction in ID/EX is a load.
- IDEX_RDaddr_i  in  5  destination register of the ID/EX instruction.
- pc_o  out  32  IF/ID PC.
- instruction_o  out  32  IF/ID instruction.
- valid_o  out  1  IF/ID holds a real (non-bubble) instruction.
- NoOp_o  out  1  zero the control signals entering ID/EX this cycle.
- load_use_cnt_o  out  CNT_W  count of load-use stall cycles.
- flush_cnt_o  out  CNT_W  count of branch flushes.

Behaviour:
- Reset (rst_i=0, asynchronous, any time including mid-stall):
  - PC=RESET_PC, pc_o=0, instruction_o=NOP_INSTR, valid_o=0, both counters=0.
  - The first fetch of RESET_PC is latched on the first posedge after release.
- instr_addr_o = PC register, combinational. instr_i is sampled the same cycle.
- Hazard detection (combinational):
  - hazard = valid_o & IDEX_MemRead_i & (IDEX_RDaddr_i != 0) & (IDEX_RDaddr_i == instruction_o[19:15] | IDEX_RDaddr_i == instruction_o[24:20]).
  - rs2 is compared for every opcode (conservative).
  - NoOp_o = hazard, independent of MemStall_i.
- Per-posedge priority, highest first:
  1. MemStall_i=1: PC, IF/ID and counters hold. Branch_i and hazard are ignored (they re-evaluate next cycle).
  2. hazard: PC and IF/ID hold. load_use_cnt +1. Branch_i is ignored because branch operands are not ready; the branch re-resolves after the bubble.
  3. Branch_i & valid_o: PC <= branch_target_i, instruction_o <= NOP_INSTR, pc_o <= PC, valid_o <= 0, flush_cnt +1.
  4. Normal: PC <= PC+4 (32-bit wrap, 0xFFFF_FFFC -> 0), pc_o <= PC, instruction_o <= instr_i, valid_o <= 1.
- Branch_i is ignored when valid_o=0.
- Counters saturate at all-ones and never wrap.
- Latency: instruction fetched at PC in cycle n appears on instruction_o in cycle n+1.
- A load-use hazard inserts exactly one bubble: NoOp_o high for one non-stalled cycle. Next cycle the load has left ID/EX and hazard drops.
- No X-propagation: all outputs are defined from reset.

Test Plan:
- Reset then 4 free cycles, instr_i = mem[PC], mem[0..12] distinct -> pc_o/instruction_o step through 0,4,8 with 1-cycle latency; valid_o=1 from the first edge.
- Load-use: ID/EX lw x5 (MemRead=1, RD=5), IF/ID add x6,x5,x7 -> NoOp_o=1; PC and IF/ID hold exactly 1 cycle; load_use_cnt=1. The same case with RD=0 -> no stall.
- Branch: Branch_i=1, target 0x40 with IF/ID at PC 0x8 -> next cycle instruction_o=0x00000013, valid_o=0, instr_addr_o=0x40; the cycle after, pc_o=0x40; flush_cnt=1.
- Simultaneous hazard+Branch_i -> stall only, PC unchanged, flush_cnt unchanged. Drop the hazard with Branch_i still 1 -> flush to target.
- MemStall_i=1 for 5 cycles during a hazard and a branch -> all outputs and counters frozen, NoOp_o tracks hazard. Release -> normal priority resumes.
- rst_i pulsed low mid-MemStall at PC 0x20 -> immediate (no clock) PC=0, instruction_o=NOP, counters 0. Counter saturation: force 70000 flushes with CNT_W=16 -> flush_cnt_o=0xFFFF.
